// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind uart_rx: first-word-fall-through read side,
// sticky overflow flag and a count of buffered end-of-line bytes.
module uart_rx_fifo #(
    parameter int                   DATA_BITS = 8,
    parameter int                   DEPTH     = 16,
    parameter logic [DATA_BITS-1:0] EOL_CHAR  = 'h0D
) (
    input  logic                     sysclk_in,
    input  logic                     nrst_in,
    input  logic                     data_rdy_in,
    input  logic [DATA_BITS-1:0]     rx_data_in,
    input  logic                     rd_en_in,
    output logic [DATA_BITS-1:0]     rd_data_out,
    output logic                     empty_out,
    output logic                     full_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     overflow_out,
    input  logic                     overflow_clr_in,
    output logic                     line_rdy_out
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [ADDR_W:0]      cnt;
    logic [ADDR_W:0]      eol_cnt;
    logic                 ovf;

    logic wr_acc;
    logic rd_acc;
    logic drop;
    logic eol_wr;
    logic eol_rd;

    assign empty_out    = (cnt == '0);
    assign full_out     = (cnt == DEPTH_C);
    assign count_out    = cnt;
    assign overflow_out = ovf;
    assign line_rdy_out = (eol_cnt != '0);
    assign rd_data_out  = empty_out ? '0 : mem[rd_ptr];

    // A pop frees the slot in the same edge, so a full FIFO still
    // takes a write when it is read at the same time.
    assign wr_acc = data_rdy_in & (~full_out | rd_en_in);
    assign rd_acc = rd_en_in & ~empty_out;
    assign drop   = data_rdy_in & full_out & ~rd_en_in;
    assign eol_wr = wr_acc & (rx_data_in == EOL_CHAR);
    assign eol_rd = rd_acc & (rd_data_out == EOL_CHAR);

    always_ff @(posedge sysclk_in) begin
        if (wr_acc) begin
            mem[wr_ptr] <= rx_data_in;
        end
    end

    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            eol_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            unique case ({eol_wr, eol_rd})
                2'b10:   eol_cnt <= eol_cnt + 1'b1;
                2'b01:   eol_cnt <= eol_cnt - 1'b1;
                default: eol_cnt <= eol_cnt;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (overflow_clr_in) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, full/empty edges,
// overflow, EOL counting, pointer wrap and async reset.
module tb_uart_rx_fifo;

    logic       sysclk;
    logic       nrst;
    logic       data_rdy;
    logic [7:0] rx_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       overflow_clr;
    logic       line_rdy;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo dut (
        .sysclk_in       (sysclk),
        .nrst_in         (nrst),
        .data_rdy_in     (data_rdy),
        .rx_data_in      (rx_data),
        .rd_en_in        (rd_en),
        .rd_data_out     (rd_data),
        .empty_out       (empty),
        .full_out        (full),
        .count_out       (count),
        .overflow_out    (overflow),
        .overflow_clr_in (overflow_clr),
        .line_rdy_out    (line_rdy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        data_rdy = 1'b1;
        rx_data  = b;
        tick();
        data_rdy = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        check(tag, rd_data, exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cnt"}, count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_line"}, line_rdy, 0);
        check({tag, "_data"}, rd_data, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] val;
        logic       w;
        logic       r;
        logic       wa;
        logic       ra;
        int         guard;

        nrst         = 1'b0;
        data_rdy     = 1'b0;
        rx_data      = '0;
        rd_en        = 1'b0;
        overflow_clr = 1'b0;
        #12;
        check_reset("rst");
        @(negedge sysclk);
        nrst = 1'b1;
        tick();

        // basic ordering and 1-cycle FWFT latency
        push(8'h61);
        check("t1_fwft", rd_data, 8'h61);
        check("t1_cnt1", count, 1);
        repeat (9) tick();
        push(8'h62);
        repeat (9) tick();
        push(8'h63);
        check("t1_cnt3", count, 3);
        pop("t1_p0", 8'h61);
        pop("t1_p1", 8'h62);
        pop("t1_p2", 8'h63);
        check("t1_empty", empty, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t1_rd_empty_cnt", count, 0);
        check("t1_rd_empty_ovf", overflow, 0);

        // fill, overflow, set beats clear
        for (int i = 0; i < 16; i++) push(i[7:0]);
        check("t2_full", full, 1);
        check("t2_cnt", count, 16);
        check("t2_ovf0", overflow, 0);
        push(8'hAA);
        check("t2_ovf1", overflow, 1);
        check("t2_cnt_drop", count, 16);
        overflow_clr = 1'b1;
        push(8'hAB);
        overflow_clr = 1'b0;
        check("t2_set_wins", overflow, 1);
        for (int i = 0; i < 16; i++) pop("t2_drain", i[7:0]);
        check("t2_empty", empty, 1);
        check("t2_ovf_held", overflow, 1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("t2_ovf_clr", overflow, 0);

        // simultaneous read/write on a full FIFO
        for (int i = 0; i < 16; i++) push(i[7:0]);
        check("t3_head", rd_data, 8'h00);
        rd_en = 1'b1;
        push(8'h55);
        rd_en = 1'b0;
        check("t3_cnt", count, 16);
        check("t3_ovf", overflow, 0);
        for (int i = 1; i < 16; i++) pop("t3_drain", i[7:0]);
        pop("t3_last", 8'h55);
        check("t3_empty", empty, 1);

        // simultaneous write/read on empty: read ignored
        rd_en = 1'b1;
        push(8'h3C);
        rd_en = 1'b0;
        check("t3e_cnt", count, 1);
        pop("t3e_data", 8'h3C);

        // end-of-line tracking
        push(8'h61);
        push(8'h62);
        check("t4_line0", line_rdy, 0);
        push(8'h0D);
        check("t4_line1", line_rdy, 1);
        pop("t4_p0", 8'h61);
        pop("t4_p1", 8'h62);
        check("t4_line_held", line_rdy, 1);
        pop("t4_p2", 8'h0D);
        check("t4_line_off", line_rdy, 0);

        // streaming with wrap, scoreboard every cycle
        for (int i = 0; i < 84; i++) begin
            w   = (i % 6 != 3) && (i % 6 != 5);
            r   = (i % 2 == 1);
            val = 8'(i * 7 + 3);
            data_rdy = w;
            rx_data  = val;
            rd_en    = r;
            check("t5_cnt", count, q.size());
            if (q.size() > 0) check("t5_data", rd_data, q[0]);
            ra = r && q.size() > 0;
            wa = w && (q.size() < 16 || r);
            tick();
            if (ra) void'(q.pop_front());
            if (wa) q.push_back(val);
        end
        data_rdy = 1'b0;
        rd_en    = 1'b0;
        guard    = 0;
        while (q.size() > 0 && guard < 40) begin
            check("t5_dcnt", count, q.size());
            pop("t5_drain", q[0]);
            void'(q.pop_front());
            guard++;
        end
        check("t5_empty", empty, 1);
        check("t5_ovf", overflow, 0);

        // async reset mid-stream
        for (int i = 0; i < 16; i++) push(8'h20 + i[7:0]);
        push(8'hEE);
        for (int i = 0; i < 11; i++) pop("t6_pop", 8'h20 + i[7:0]);
        check("t6_pre_cnt", count, 5);
        check("t6_pre_ovf", overflow, 1);
        #2;
        nrst = 1'b0;
        #1;
        check_reset("t6");
        @(negedge sysclk);
        nrst = 1'b1;
        tick();
        push(8'h77);
        check("t6_after", rd_data, 8'h77);
        check("t6_after_cnt", count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
